// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants used by the sequential multiplier
package cpu_pkg;

    // Multiplier control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 16;

    // Bit position of the multiply-start field in the execute control word
    localparam int CTRL_MUL_START_BIT = 4;

endpackage

// File: rtl/seq_mul_unit_abs_neg.sv
// rtl/seq_mul_unit_abs_neg.sv - combinational conditional two's-complement negate
module abs_neg #(
    parameter int W = 16
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_o
);

    // Negate when requested; the most negative value maps onto itself, which
    // read as unsigned is exactly its magnitude.
    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - shift-add sequential multiplier with start/busy/done and stall (optional SEQ_MUL_EARLY_TERM_EN)
module seq_mul_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               stall,
    output logic [2*WIDTH-1:0] product
);

    mul_state_t           state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     mplier_d;
    logic [CNT_W-1:0]     cnt_d;
    logic [2*WIDTH-1:0]   result;
    logic                 last_iter;
    logic                 load_zero;

    // Operand magnitudes for the unsigned shift-add core
    abs_neg #(.W(WIDTH)) u_abs_a (
        .neg_i (is_signed & a[WIDTH-1]),
        .val_i (a),
        .res_o (mag_a)
    );

    abs_neg #(.W(WIDTH)) u_abs_b (
        .neg_i (is_signed & b[WIDTH-1]),
        .val_i (b),
        .res_o (mag_b)
    );

    // One shift-add step; mcand_q is pre-shifted so no variable shifter is needed
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
    end

    // Sign restore applied to the accumulator value being finalised
    abs_neg #(.W(2*WIDTH)) u_res (
        .neg_i (neg_q),
        .val_i (acc_d),
        .res_o (result)
    );

`ifdef SEQ_MUL_EARLY_TERM_EN
    // Stop as soon as no multiplier bits remain; a zero multiplier finishes on load
    assign last_iter = (cnt_q == CNT_W'(1)) || (mplier_d == '0);
    assign load_zero = (mag_b == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(1));
    assign load_zero = 1'b0;
`endif

    // Control FSM with operand load, iteration and finalisation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        if (load_zero) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    mcand_q  <= mcand_q << 1;
                    cnt_q    <= cnt_d;
                    if (last_iter) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= result;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign stall   = (start & ~busy_q) | busy_q;

endmodule
